// File: rtl/ps2_keyscan_rx.sv
// PS/2 keyboard receiver: frames 11-bit packets, decodes make/break/E0, tracks held note keys
// and queues key events in a first-word-fall-through FIFO. Optional macro: PS2_PARITY_CHECK_EN.
module ps2_keyscan_rx #(
    parameter int unsigned            NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0]  KEY_TABLE      = {8'h2B, 8'h23, 8'h1B, 8'h1C},
    parameter int unsigned            FIFO_DEPTH     = 4,
    parameter int unsigned            TIMEOUT_CYCLES = 50000,
    parameter int unsigned            SYNC_STAGES    = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [7:0]          evt_code,
    output logic                evt_release,
    output logic                evt_ext,
    output logic                overflow,
    output logic                frame_err
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
`ifdef PS2_PARITY_CHECK_EN
    logic                   parity_q, parity_d;
`endif
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic                   ferr_q, ferr_d;
    logic                   ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [NUM_KEYS-1:0]    key_held_q, key_held_d;
    logic                   ovf_q, ovf_d;
    logic [9:0]             mem_q [FIFO_DEPTH];
    logic [9:0]             mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic                   clk_s, data_s, fall, byte_ok;
    logic                   push, pop, full, do_push, found, typematic;
    logic [NUM_KEYS-1:0]    hit_mask;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;

    // Frame FSM and inactivity timeout
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
`ifdef PS2_PARITY_CHECK_EN
        parity_d    = parity_q;
`endif
        tmo_d       = tmo_q;
        ferr_d      = 1'b0;
        byte_ok     = 1'b0;

        if (state_q == StIdle || fall) begin
            tmo_d = '0;
        end else if (tmo_q == TmoLast) begin
            tmo_d   = '0;
            state_d = StIdle;
            ferr_d  = 1'b1;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end

        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = data_s;
`endif
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!data_s) begin
                        ferr_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    end else if (!(^{shift_q, parity_q})) begin
                        ferr_d = 1'b1;
`endif
                    end else begin
                        byte_ok = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Byte decode, held-key bitmap and event FIFO
    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        key_held_d = key_held_q;
        push       = 1'b0;
        typematic  = 1'b0;
        found      = 1'b0;
        hit_mask   = '0;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        // Lowest matching table index wins
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!found && KEY_TABLE[8*i +: 8] == shift_q) begin
                hit_mask[i] = 1'b1;
                found       = 1'b1;
            end
        end

        if (byte_ok) begin
            if (shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
                if (shift_q != 8'h00 && shift_q != 8'hFF) begin
                    if (!ext_pend_q) begin
                        if (brk_pend_q) begin
                            key_held_d = key_held_q & ~hit_mask;
                        end else begin
                            typematic  = |(key_held_q & hit_mask);
                            key_held_d = key_held_q | hit_mask;
                        end
                    end
                    push = !typematic;
                end
            end
        end

        pop     = (cnt_q != '0) && evt_ready;
        full    = (cnt_q == CntW'(FIFO_DEPTH));
        do_push = push && (!full || pop);
        ovf_d   = push && full && !pop;

        if (do_push) begin
            mem_d[wr_ptr_q] = {ext_pend_q, brk_pend_q, shift_q};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
        cnt_d = cnt_q + CntW'(do_push) - CntW'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
            tmo_q       <= '0;
            ferr_q      <= 1'b0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            key_held_q  <= '0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= parity_d;
`endif
            tmo_q       <= tmo_d;
            ferr_q      <= ferr_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            key_held_q  <= key_held_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign key_held    = key_held_q;
    assign evt_valid   = (cnt_q != '0);
    assign evt_code    = mem_q[rd_ptr_q][7:0];
    assign evt_release = mem_q[rd_ptr_q][8];
    assign evt_ext     = mem_q[rd_ptr_q][9];
    assign overflow    = ovf_q;
    assign frame_err   = ferr_q;

endmodule

// File: tb/tb_ps2_keyscan_rx.sv
// Directed bench for ps2_keyscan_rx: drives PS/2 frames, logs popped events and pulse counts.
module tb_ps2_keyscan_rx;
    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] key_held;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_release;
    logic       evt_ext;
    logic       overflow;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int ovf_cnt  = 0;
    int ferr_cnt = 0;
    int base;
    logic [9:0] evlog[$];

    ps2_keyscan_rx #(
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_held    (key_held),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_code    (evt_code),
        .evt_release (evt_release),
        .evt_ext     (evt_ext),
        .overflow    (overflow),
        .frame_err   (frame_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (overflow) ovf_cnt++;
        if (frame_err) ferr_cnt++;
        if (evt_valid && evt_ready) evlog.push_back({evt_ext, evt_release, evt_code});
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        #40 ps2_clk = 1'b0;
        #40 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ flip_par);
        ps2_bit(stop);
        ps2_data = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        evt_ready = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_key_held", 32'(key_held), 32'h0);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);

        // Make 1C held in FIFO
        send_byte(8'h1C);
        check("mk1c_valid", 32'(evt_valid), 32'h1);
        check("mk1c_head", 32'({evt_ext, evt_release, evt_code}), 32'h01C);
        check("mk1c_held", 32'(key_held), 32'h1);
        evt_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("mk1c_drained", 32'(evt_valid), 32'h0);
        evlog.delete();

        // Break 1C
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("brk1c_n", 32'(evlog.size()), 32'd1);
        if (evlog.size() > 0) check("brk1c_evt", 32'(evlog[0]), 32'h11C);
        check("brk1c_held", 32'(key_held), 32'h0);
        evlog.delete();

        // Typematic repeats filtered
        repeat (3) send_byte(8'h23);
        check("typ_n", 32'(evlog.size()), 32'd1);
        if (evlog.size() > 0) check("typ_evt", 32'(evlog[0]), 32'h023);
        check("typ_held", 32'(key_held), 32'h4);
        evlog.delete();

        // Lone prefixes then FF clear: no events
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'hFF);
        check("pfx_none", 32'(evlog.size()), 32'd0);

        // Extended make / break
        send_byte(8'hE0);
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("ext_n", 32'(evlog.size()), 32'd2);
        if (evlog.size() > 1) begin
            check("ext_mk", 32'(evlog[0]), 32'h21C);
            check("ext_brk", 32'(evlog[1]), 32'h31C);
        end
        check("ext_held", 32'(key_held), 32'h4);
        send_byte(8'hF0);
        send_byte(8'h23);
        check("rel23_held", 32'(key_held), 32'h0);
        evlog.delete();

        // Overflow with consumer stalled
        evt_ready = 1'b0;
        base = ovf_cnt;
        send_byte(8'h1C);
        send_byte(8'h1B);
        send_byte(8'h23);
        send_byte(8'h2B);
        send_byte(8'h15);
        check("ovf_pulses", 32'(ovf_cnt - base), 32'd1);
        check("ovf_held", 32'(key_held), 32'hF);
        check("ovf_head", 32'({evt_ext, evt_release, evt_code}), 32'h01C);
        evt_ready = 1'b1;
        repeat (8) @(negedge clock);
        check("ovf_n", 32'(evlog.size()), 32'd4);
        if (evlog.size() > 3) begin
            check("ovf_e0", 32'(evlog[0]), 32'h01C);
            check("ovf_e1", 32'(evlog[1]), 32'h01B);
            check("ovf_e2", 32'(evlog[2]), 32'h023);
            check("ovf_e3", 32'(evlog[3]), 32'h02B);
        end
        check("ovf_empty", 32'(evt_valid), 32'h0);
        send_byte(8'hF0);
        send_byte(8'h1B);
        check("rel1b_held", 32'(key_held), 32'hD);
        evlog.delete();

        // Partial frame abandoned by timeout
        base = ferr_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (300) @(negedge clock);
        check("tmo_ferr", 32'(ferr_cnt - base), 32'd1);
        check("tmo_noevt", 32'(evlog.size()), 32'd0);
        send_byte(8'h1B);
        check("tmo_next_n", 32'(evlog.size()), 32'd1);
        if (evlog.size() > 0) check("tmo_next_evt", 32'(evlog[0]), 32'h01B);
        check("tmo_next_held", 32'(key_held), 32'hF);
        evlog.delete();

        // Bad stop bit
        base = ferr_cnt;
        send_frame(8'h15, 1'b0, 1'b0);
        check("stop_ferr", 32'(ferr_cnt - base), 32'd1);
        check("stop_noevt", 32'(evlog.size()), 32'd0);

        // Inverted parity on a fresh 1C make
        send_byte(8'hF0);
        send_byte(8'h1C);
        evlog.delete();
        base = ferr_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check("par_ferr", 32'(ferr_cnt - base), 32'd1);
        check("par_noevt", 32'(evlog.size()), 32'd0);
        check("par_held", 32'(key_held), 32'hE);
`else
        check("par_ferr", 32'(ferr_cnt - base), 32'd0);
        check("par_n", 32'(evlog.size()), 32'd1);
        if (evlog.size() > 0) check("par_evt", 32'(evlog[0]), 32'h01C);
        check("par_held", 32'(key_held), 32'hF);
`endif

        // Reset mid-stream clears state
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst2_held", 32'(key_held), 32'h0);
        check("rst2_valid", 32'(evt_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
